// File: rtl/game_pkg.sv
// game_pkg: direction, game/player state codes and grid geometry shared with the action block
package game_pkg;
  typedef enum logic [1:0] {LEFT = 2'd0, RIGHT = 2'd1, UP = 2'd2, DOWN = 2'd3} dir_e;
  typedef enum logic [2:0] {GS_START = 3'd0, GS_PLAY = 3'd1, GS_PAUSE = 3'd2, GS_END = 3'd3} gs_e;
  localparam logic [3:0] PS_CHOPPING = 4'd1;
  localparam int TILE_SHIFT = 5;
  localparam int GRID_COLS = 13;
  localparam int GRID_ROWS = 8;
  localparam logic signed [9:0] X_LIM = 10'sd415;
  localparam logic signed [9:0] Y_LIM = 10'sd255;
endpackage

// File: rtl/player_move_if.sv
// player_move_if: buttons, game context and walkable map in; player pose and status out
interface player_move_if;
  import game_pkg::*;
  logic left, right, up, down;
  logic [2:0] game_state;
  logic [3:0] player_state;
  logic [GRID_ROWS-1:0][GRID_COLS-1:0] walkable;
  logic [1:0] player_direction;
  logic [8:0] player_loc_x, player_loc_y;
  logic moving, bump;
  modport master (
    output left, right, up, down, game_state, player_state, walkable,
    input player_direction, player_loc_x, player_loc_y, moving, bump
  );
  modport slave (
    input left, right, up, down, game_state, player_state, walkable,
    output player_direction, player_loc_x, player_loc_y, moving, bump
  );
endinterface

// File: rtl/tile_probe.sv
// tile_probe: maps a signed pixel point to an on-grid flag and its tile's walkable bit
module tile_probe
  import game_pkg::*;
(
  input  logic signed [9:0] px,
  input  logic signed [9:0] py,
  input  logic [GRID_ROWS-1:0][GRID_COLS-1:0] walkable,
  output logic in_range,
  output logic walk
);
  assign in_range = px >= 10'sd0 && px <= X_LIM && py >= 10'sd0 && py <= Y_LIM;
  assign walk = in_range & walkable[py[TILE_SHIFT+2:TILE_SHIFT]][px[TILE_SHIFT+3:TILE_SHIFT]];
endmodule

// File: rtl/player_move.sv
// player_move: per-frame player step with wall/counter collision and chop lock
module player_move
  import game_pkg::*;
#(
  parameter int SPEED = 2,
  parameter int HALF = 12,
  parameter int SPAWN_X = 300,
  parameter int SPAWN_Y = 208
) (
  input logic vsync,
  input logic reset,
  player_move_if.slave bus
);
  localparam logic signed [9:0] SPD = 10'(SPEED);
  localparam logic signed [9:0] HLF = 10'(HALF);
  localparam logic [8:0] SX = 9'(SPAWN_X);
  localparam logic [8:0] SY = 9'(SPAWN_Y);
  logic [8:0] x_q, x_d, y_q, y_d;
  dir_e dir_q, dir_d, req_dir;
  logic moving_q, moving_d, bump_q, bump_d;
  logic req, horiz, neg, start, go, ok;
  logic signed [9:0] xs, ys, cx, cy, ex, ey, p0x, p0y, p1x, p1y;
  logic in0, in1, w0, w1;
  // Pick the requested direction and the two leading-edge corners of the candidate box
  always_comb begin
    req = bus.left | bus.right | bus.up | bus.down;
    req_dir = bus.left ? LEFT : bus.right ? RIGHT : bus.up ? UP : DOWN;
    horiz = req_dir == LEFT || req_dir == RIGHT;
    neg = req_dir == LEFT || req_dir == UP;
    xs = signed'({1'b0, x_q});
    ys = signed'({1'b0, y_q});
    cx = horiz ? (neg ? xs - SPD : xs + SPD) : xs;
    cy = horiz ? ys : (neg ? ys - SPD : ys + SPD);
    ex = neg ? cx - HLF : cx + HLF;
    ey = neg ? cy - HLF : cy + HLF;
    p0x = horiz ? ex : cx - HLF;
    p1x = horiz ? ex : cx + HLF;
    p0y = horiz ? cy - HLF : ey;
    p1y = horiz ? cy + HLF : ey;
  end
  tile_probe u_probe0 (.px(p0x), .py(p0y), .walkable(bus.walkable), .in_range(in0), .walk(w0));
  tile_probe u_probe1 (.px(p1x), .py(p1y), .walkable(bus.walkable), .in_range(in1), .walk(w1));
  // Commit, block or hold the step depending on game state and chop lock
  always_comb begin
    ok = in0 & w0 & in1 & w1;
    start = bus.game_state == GS_START;
    go = bus.game_state == GS_PLAY && bus.player_state != PS_CHOPPING && req;
    x_d = start ? SX : (go && ok) ? cx[8:0] : x_q;
    y_d = start ? SY : (go && ok) ? cy[8:0] : y_q;
    dir_d = go ? req_dir : dir_q;
    moving_d = go && ok;
    bump_d = go && !ok;
  end
  // Frame-rate state register; reset overrides any step in progress
  always_ff @(posedge vsync) begin
    if (reset) begin
      x_q <= SX;
      y_q <= SY;
      dir_q <= LEFT;
      moving_q <= 1'b0;
      bump_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      dir_q <= dir_d;
      moving_q <= moving_d;
      bump_q <= bump_d;
    end
  end
  assign bus.player_loc_x = x_q;
  assign bus.player_loc_y = y_q;
  assign bus.player_direction = dir_q;
  assign bus.moving = moving_q;
  assign bus.bump = bump_q;
endmodule

// File: tb/tb_player_move.sv
// tb_player_move: scoreboard bench for player_move with directed test-plan checks
module tb_player_move;
  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [1:0] dir;
    logic mv;
    logic bp;
  } exp_t;
  logic vsync = 1'b0;
  logic reset = 1'b0;
  player_move_if bus ();
  player_move dut (.vsync(vsync), .reset(reset), .bus(bus));
  always #5 vsync = ~vsync;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_x = 300, m_y = 208, m_dir = 0;
  logic [7:0][12:0] map;
  function automatic bit floor_at(input int px, input int py);
    if (px < 0 || px > 415 || py < 0 || py > 255) return 1'b0;
    return map[py / 32][px / 32];
  endfunction
  task automatic step(input logic rs, input logic l, input logic r, input logic u, input logic d,
                      input logic [2:0] gs, input logic [3:0] ps);
    exp_t e, got;
    int cx, cy, ax, ay, bx, by;
    bit mv = 0, bp = 0;
    reset = rs;
    bus.left = l; bus.right = r; bus.up = u; bus.down = d;
    bus.game_state = gs; bus.player_state = ps; bus.walkable = map;
    if (rs || gs == 3'd0) begin
      m_x = 300; m_y = 208;
      if (rs) m_dir = 0;
    end else if (gs == 3'd1 && ps != 4'd1 && (l || r || u || d)) begin
      m_dir = l ? 0 : r ? 1 : u ? 2 : 3;
      cx = m_x; cy = m_y;
      if (m_dir == 0) cx = cx - 2;
      if (m_dir == 1) cx = cx + 2;
      if (m_dir == 2) cy = cy - 2;
      if (m_dir == 3) cy = cy + 2;
      if (m_dir < 2) begin
        ax = (m_dir == 0) ? cx - 12 : cx + 12; bx = ax; ay = cy - 12; by = cy + 12;
      end else begin
        ay = (m_dir == 2) ? cy - 12 : cy + 12; by = ay; ax = cx - 12; bx = cx + 12;
      end
      if (floor_at(ax, ay) && floor_at(bx, by)) begin
        m_x = cx; m_y = cy; mv = 1;
      end else bp = 1;
    end
    e.x = 9'(m_x); e.y = 9'(m_y); e.dir = 2'(m_dir); e.mv = mv; e.bp = bp;
    sb.push_back(e);
    @(posedge vsync);
    #1;
    reset = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      got = {bus.player_loc_x, bus.player_loc_y, bus.player_direction, bus.moving, bus.bump};
      if (got !== e) begin
        errors++;
        $display("FAIL step got x=%0d y=%0d dir=%0d mv=%0b bump=%0b want x=%0d y=%0d dir=%0d mv=%0b bump=%0b",
                 got.x, got.y, got.dir, got.mv, got.bp, e.x, e.y, e.dir, e.mv, e.bp);
      end
    end
  endtask
  task automatic test_reset;
    map = '1;
    step(1, 0, 0, 0, 0, 3'd1, 4'd0);
    checks++;
    if ({bus.player_loc_x, bus.player_loc_y, bus.player_direction, bus.moving, bus.bump} !== {9'd300, 9'd208, 2'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_state got %0d,%0d dir %0d want 300,208 dir 0", bus.player_loc_x, bus.player_loc_y, bus.player_direction);
    end
  endtask
  task automatic test_right;
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, 0, 0, 3'd1, 4'd0);
      checks++;
      if (bus.player_loc_x !== 9'(300 + 2 * i) || bus.player_direction !== 2'd1 || bus.moving !== 1'b1) begin
        errors++;
        $display("FAIL right_move got x=%0d dir=%0d mv=%0b want x=%0d dir=1 mv=1", bus.player_loc_x, bus.player_direction, bus.moving, 300 + 2 * i);
      end
    end
  endtask
  task automatic test_wall;
    for (int r = 0; r < 8; r++) map[r][0] = 1'b0;
    for (int i = 0; i < 131; i++) step(0, 1, 0, 0, 0, 3'd1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 3'd1, 4'd0);
      checks++;
      if (bus.player_loc_x !== 9'd44 || bus.bump !== 1'b1 || bus.moving !== 1'b0 || bus.player_direction !== 2'd0) begin
        errors++;
        $display("FAIL wall_bump got x=%0d bump=%0b mv=%0b want x=44 bump=1 mv=0", bus.player_loc_x, bus.bump, bus.moving);
      end
    end
  endtask
  task automatic test_priority;
    map = '1;
    step(0, 1, 0, 1, 0, 3'd1, 4'd0);
    checks++;
    if (bus.player_loc_x !== 9'd42 || bus.player_loc_y !== 9'd208 || bus.player_direction !== 2'd0) begin
      errors++;
      $display("FAIL priority got %0d,%0d dir %0d want 42,208 dir 0", bus.player_loc_x, bus.player_loc_y, bus.player_direction);
    end
    step(0, 0, 1, 0, 0, 3'd1, 4'd0);
    step(0, 1, 0, 1, 0, 3'd0, 4'd0);
    checks++;
    if (bus.player_loc_x !== 9'd300 || bus.player_loc_y !== 9'd208 || bus.player_direction !== 2'd1 || bus.moving !== 1'b0) begin
      errors++;
      $display("FAIL start_spawn got %0d,%0d dir %0d want 300,208 dir 1", bus.player_loc_x, bus.player_loc_y, bus.player_direction);
    end
  endtask
  task automatic test_chop;
    step(0, 0, 0, 1, 0, 3'd1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, 3'd1, 4'd1);
      checks++;
      if (bus.player_loc_x !== 9'd300 || bus.player_loc_y !== 9'd206 || bus.player_direction !== 2'd2 || bus.moving !== 1'b0) begin
        errors++;
        $display("FAIL chop_lock got %0d,%0d dir %0d mv %0b want 300,206 dir 2 mv 0", bus.player_loc_x, bus.player_loc_y, bus.player_direction, bus.moving);
      end
    end
    step(0, 0, 1, 0, 0, 3'd1, 4'd0);
    checks++;
    if (bus.player_loc_x !== 9'd302 || bus.player_direction !== 2'd1 || bus.moving !== 1'b1) begin
      errors++;
      $display("FAIL chop_release got x=%0d dir=%0d want x=302 dir=1", bus.player_loc_x, bus.player_direction);
    end
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0, 3'd1, 4'd0);
    step(1, 0, 1, 0, 0, 3'd1, 4'd0);
    checks++;
    if (bus.player_loc_x !== 9'd300 || bus.player_loc_y !== 9'd208 || bus.player_direction !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid got %0d,%0d dir %0d want 300,208 dir 0", bus.player_loc_x, bus.player_loc_y, bus.player_direction);
    end
    step(0, 0, 1, 0, 0, 3'd1, 4'd0);
    checks++;
    if (bus.player_loc_x !== 9'd302 || bus.moving !== 1'b1) begin
      errors++;
      $display("FAIL reset_resume got x=%0d mv=%0b want x=302 mv=1", bus.player_loc_x, bus.moving);
    end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 3'd1, 4'd0);
    checks++;
    if (bus.player_loc_y !== 9'd242 || bus.bump !== 1'b1) begin
      errors++;
      $display("FAIL bottom_edge got y=%0d bump=%0b want y=242 bump=1", bus.player_loc_y, bus.bump);
    end
    step(0, 0, 0, 0, 0, 3'd1, 4'd0);
    step(0, 0, 1, 0, 0, 3'd2, 4'd0);
    checks++;
    if (bus.player_loc_x !== 9'd302 || bus.moving !== 1'b0 || bus.player_direction !== 2'd3) begin
      errors++;
      $display("FAIL pause_hold got x=%0d mv=%0b dir=%0d want x=302 mv=0 dir=3", bus.player_loc_x, bus.moving, bus.player_direction);
    end
  endtask
  initial begin
    test_reset;
    test_right;
    test_wall;
    test_priority;
    test_chop;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
